// File: rtl/deserializer.sv
// Serial-to-parallel receiver for the MSB-first serializer link: rebuilds 3..DATA_W-bit words
// and pulses each out with its bit count in mod format (DATA_W encoded as 0).
module deserializer #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned MIN_BITS = 3,
   localparam int unsigned MOD_W   = $clog2(DATA_W)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              ser_data_i,
   input  logic              ser_data_val_i,
   output logic [DATA_W-1:0] deser_data_o,
   output logic [MOD_W-1:0]  deser_data_mod_o,
   output logic              deser_data_val_o,
   output logic              short_drop_o,
   output logic              busy_o
);

   localparam int unsigned CNT_W = MOD_W + 1;

   typedef enum logic [0:0] {StIdle, StRecv} state_e;

   state_e            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [CNT_W-1:0]  cnt_inc;
   logic [DATA_W-1:0] sr_q;
   logic [DATA_W-1:0] sr_ins;
   logic [MOD_W-1:0]  bit_pos;
   logic [DATA_W-1:0] data_q;
   logic [MOD_W-1:0]  mod_q;
   logic              val_q;
   logic              drop_q;
   logic              busy_q;

   // Shift register with the incoming bit placed at the next MSB-first position.
   always_comb begin
      cnt_inc = cnt_q + CNT_W'(1);
      bit_pos = MOD_W'(DATA_W - 1) - cnt_q[MOD_W-1:0];
      sr_ins  = sr_q;
      sr_ins[bit_pos] = ser_data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         sr_q    <= '0;
         data_q  <= '0;
         mod_q   <= '0;
         val_q   <= 1'b0;
         drop_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         val_q  <= 1'b0;
         drop_q <= 1'b0;
         case (state_q)
            StIdle: begin
               if (ser_data_val_i) begin
                  sr_q    <= sr_ins;
                  cnt_q   <= cnt_inc;
                  busy_q  <= 1'b1;
                  state_q <= StRecv;
               end
            end
            StRecv: begin
               if (ser_data_val_i) begin
                  if (cnt_inc == CNT_W'(DATA_W)) begin
                     // Full word: emit now so a new MSB may follow with no gap.
                     data_q  <= sr_ins;
                     mod_q   <= cnt_inc[MOD_W-1:0];
                     val_q   <= 1'b1;
                     cnt_q   <= '0;
                     sr_q    <= '0;
                     busy_q  <= 1'b0;
                     state_q <= StIdle;
                  end else begin
                     sr_q   <= sr_ins;
                     cnt_q  <= cnt_inc;
                     busy_q <= 1'b1;
                  end
               end else begin
                  if (cnt_q >= CNT_W'(MIN_BITS)) begin
                     data_q <= sr_q;
                     mod_q  <= cnt_q[MOD_W-1:0];
                     val_q  <= 1'b1;
                  end else begin
                     drop_q <= 1'b1;
                  end
                  cnt_q   <= '0;
                  sr_q    <= '0;
                  busy_q  <= 1'b0;
                  state_q <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign deser_data_o     = data_q;
   assign deser_data_mod_o = mod_q;
   assign deser_data_val_o = val_q;
   assign short_drop_o     = drop_q;
   assign busy_o           = busy_q;

   a_pulse_excl: assert property (@(posedge clk_i) disable iff (rst_i) !(val_q && drop_q));

endmodule

// File: tb/tb_deserializer.sv
// Scoreboard bench for deserializer: stimulus pushes expected word/drop events with their
// cycle; a negedge monitor pops and compares every pulse the DUT produces.
module tb_deserializer;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        ser_data_i = 1'b0;
   logic        ser_data_val_i = 1'b0;
   logic [15:0] deser_data_o;
   logic [3:0]  deser_data_mod_o;
   logic        deser_data_val_o;
   logic        short_drop_o;
   logic        busy_o;

   deserializer #(.DATA_W(16), .MIN_BITS(3)) dut (
      .clk_i            (clk_i),
      .rst_i            (rst_i),
      .ser_data_i       (ser_data_i),
      .ser_data_val_i   (ser_data_val_i),
      .deser_data_o     (deser_data_o),
      .deser_data_mod_o (deser_data_mod_o),
      .deser_data_val_o (deser_data_val_o),
      .short_drop_o     (short_drop_o),
      .busy_o           (busy_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic        is_drop;
      logic [15:0] data;
      logic [3:0]  mod;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] model_data = '0;
   logic [3:0]  model_mod = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic push_val(input logic [15:0] d, input logic [3:0] m, input int c);
      exp_t e;
      e.is_drop = 1'b0; e.data = d; e.mod = m; e.cyc = c;
      model_data = d;
      model_mod = m;
      sb.push_back(e);
   endtask

   task automatic push_drop(input int c);
      exp_t e;
      e.is_drop = 1'b1; e.data = model_data; e.mod = model_mod; e.cyc = c;
      sb.push_back(e);
   endtask

   task automatic drive(input logic b, input logic v);
      @(posedge clk_i);
      #1;
      ser_data_i = b;
      ser_data_val_i = v;
   endtask

   // Sends the top len bits of d MSB-first; optional gap cycle afterwards.
   task automatic send_word(input logic [15:0] d, input int len, input bit gap);
      logic [15:0] aligned;
      aligned = (len == 16) ? d : (d & (16'hFFFF << (16 - len)));
      for (int i = 0; i < len; i++) drive(d[15-i], 1'b1);
      if (len == 16) push_val(aligned, 4'd0, cyc + 1);
      if (gap) begin
         drive(1'b0, 1'b0);
         if (len < 16) begin
            if (len >= 3) push_val(aligned, 4'(len), cyc + 1);
            else push_drop(cyc + 1);
         end
      end
   endtask

   // Monitor: every pulse must match the head of the scoreboard, including its cycle.
   always @(negedge clk_i) begin
      if (!rst_i && (deser_data_val_o || short_drop_o)) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_pulse actual val=%0b drop=%0b required none (t=%0t)",
                     deser_data_val_o, short_drop_o, $time);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("pulse_kind", {30'd0, deser_data_val_o, short_drop_o},
                e.is_drop ? 32'd1 : 32'd2);
            chk("pulse_data", {16'd0, deser_data_o}, {16'd0, e.data});
            chk("pulse_mod", {28'd0, deser_data_mod_o}, {28'd0, e.mod});
            chk("pulse_cycle", cyc, e.cyc);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      #2;
      chk("rst_data", {16'd0, deser_data_o}, 32'd0);
      chk("rst_val", {31'd0, deser_data_val_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;

      // Full word
      for (int i = 0; i < 16; i++) begin
         drive(16'hA5C3 >> (15 - i), 1'b1);
         if (i == 0) push_val(16'hA5C3, 4'd0, cyc + 16);
      end
      @(negedge clk_i);
      chk("full_busy_mid", {31'd0, busy_o}, 32'd1);
      drive(1'b0, 1'b0);
      @(negedge clk_i);
      chk("full_val", {31'd0, deser_data_val_o}, 32'd1);
      chk("full_busy_after", {31'd0, busy_o}, 32'd0);

      // Short word 1,0,1,1,0 -> B000 mod 5
      send_word(16'hB000, 5, 1'b1);
      // Short run drop
      send_word(16'hC000, 2, 1'b1);
      @(negedge clk_i);
      @(negedge clk_i);
      chk("drop_busy", {31'd0, busy_o}, 32'd0);
      chk("drop_data_held", {16'd0, deser_data_o}, 32'h0000B000);

      // Back-to-back full word then 3-bit word
      send_word(16'hFFFF, 16, 1'b0);
      send_word(16'h4000, 3, 1'b1);
      repeat (3) @(negedge clk_i);
      chk("sb_empty_pre_reset", sb.size(), 32'd0);

      // Async reset mid-word
      for (int i = 0; i < 7; i++) drive(16'h1234 >> (15 - i), 1'b1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("arst_data", {16'd0, deser_data_o}, 32'd0);
      chk("arst_mod", {28'd0, deser_data_mod_o}, 32'd0);
      chk("arst_busy", {31'd0, busy_o}, 32'd0);
      chk("arst_val", {31'd0, deser_data_val_o}, 32'd0);
      model_data = '0;
      model_mod = '0;
      ser_data_val_i = 1'b0;
      @(negedge clk_i);
      rst_i = 1'b0;
      send_word(16'h1234, 16, 1'b1);

      // Loopback-style random traffic as a serializer would produce it
      for (int n = 0; n < 80; n++) begin
         int unsigned m;
         logic [15:0] d;
         m = $urandom_range(0, 15);
         d = 16'($urandom);
         if (m == 1 || m == 2) begin
            drive(1'b0, 1'b0);
         end else if (m == 0) begin
            send_word(d, 16, 1'($urandom_range(0, 1)));
         end else begin
            send_word(d, int'(m), 1'b1);
         end
         if ($urandom_range(0, 3) == 0) drive(1'b0, 1'b0);
      end
      // A few random short runs mixed in
      for (int n = 0; n < 6; n++) send_word(16'($urandom), int'($urandom_range(1, 2)), 1'b1);

      drive(1'b0, 1'b0);
      repeat (4) @(negedge clk_i);
      chk("sb_empty_end", sb.size(), 32'd0);
      chk("final_busy", {31'd0, busy_o}, 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/deserializer.md
Name: deserializer

Overview:
- Receive-side counterpart of the team's 16-bit MSB-first serializer.
- Samples a serial bit stream (bit + valid) and reassembles variable-length words of 3..16 bits, MSB-aligned.
- Outputs each word as a one-cycle parallel pulse with its bit count encoded in the serializer's mod format.
- Sits at the far end of the serial link, feeding parallel consumers.

Parameters:
DATA_W, 16, parallel word width; max bits per word
MIN_BITS, 3, shortest legal word; shorter runs are discarded
(localparam MOD_W = $clog2(DATA_W), 4 at default)

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_i  input  1  reset, asynchronous, active-high
ser_data_i  input  1  serial data bit, first bit = word MSB
ser_data_val_i  input  1  ser_data_i valid this cycle
deser_data_o  output  DATA_W  reassembled word, MSB-aligned, unused low bits zero
deser_data_mod_o  output  MOD_W  received bit count; DATA_W encoded as 0
deser_data_val_o  output  1  one-cycle pulse: deser_data_o/deser_data_mod_o valid
short_drop_o  output  1  one-cycle pulse: run shorter than MIN_BITS discarded
busy_o  output  1  partial word held (bit counter != 0)

Behaviour:
- Reset (asynchronous, rst_i=1): all outputs 0; bit counter 0; shift register 0; FSM in IDLE. Effective immediately; any partial word is discarded with no val or drop pulse.
- State: bit counter cnt (0..DATA_W, MOD_W+1 bits) and DATA_W shift register sr. FSM states are IDLE (cnt=0) and RECV (cnt>0). busy_o is registered and equals (next cnt != 0).
- Bit capture: each cycle with ser_data_val_i=1, ser_data_i is written to sr[DATA_W-1-cnt] and cnt increments. First bit lands in bit DATA_W-1. Bits below the last written position are zero; sr is cleared when a word is emitted or dropped.
- Full word: when the DATA_W-th bit is sampled at cycle N:
  - deser_data_val_o=1 at N+1, deser_data_o = assembled word, deser_data_mod_o=0.
  - cnt returns to 0 in the same update.
  - If ser_data_val_i is also 1 at N+1, that bit is the MSB of a new word; no gap is required.
- Short word, terminated by a valid gap: in RECV, a cycle N with ser_data_val_i=0 ends the word, and the following applies at N+1:
  - If cnt >= MIN_BITS: deser_data_val_o=1, deser_data_o = MSB-aligned bits, deser_data_mod_o = cnt.
  - If 0 < cnt < MIN_BITS: short_drop_o=1, deser_data_val_o=0, deser_data_o unchanged.
  - In both cases cnt goes to 0 and sr is cleared.
- Latency: full word is 1 cycle after the last bit; gap-terminated word is 2 cycles after the last bit.
- IDLE with ser_data_val_i=0: no action; no pulses.
- deser_data_o and deser_data_mod_o hold their last emitted values between pulses. They are only updated when deser_data_val_o pulses.
- deser_data_val_o and short_drop_o are never high in the same cycle. Each is high for exactly one cycle per event.
- No backpressure: the consumer must accept every pulse.
- Width rules: cnt compares against DATA_W and MIN_BITS unsigned. The mod encoding is cnt truncated to MOD_W bits, which yields 0 exactly for DATA_W.

Test Plan:
- Full word: after reset, drive 16 consecutive valid bits of 16'hA5C3 MSB first -> one cycle after the 16th bit, deser_data_val_o=1, deser_data_o=16'hA5C3, deser_data_mod_o=0; busy_o=0 the same cycle.
- Short word: 5 valid bits 1,0,1,1,0 then val low -> 2 cycles after the last bit, deser_data_val_o=1, deser_data_o=16'hB000, deser_data_mod_o=5.
- Short-run drop: 2 valid bits 1,1 then val low -> short_drop_o pulses once; deser_data_val_o stays 0; deser_data_o keeps its previous value; busy_o returns 0.
- Back-to-back: 16 bits of 16'hFFFF immediately followed by 3 bits 0,1,0 then val low -> two val pulses: 16'hFFFF/mod 0, then 16'h4000/mod 3.
- Async reset: assert rst_i asynchronously mid-clock after 7 of 16 bits -> outputs and busy_o drop to 0 without a clock edge; no val or drop pulse. After release, 16 bits of 16'h1234 -> single pulse with 16'h1234, mod 0.
- Loopback with serializer: random data_i and data_mod_i 0..15 -> each accepted word is reproduced with matching mod and MSB-aligned bits. mod 1/2 inputs produce no traffic and no pulses.
